dds_param_scheduler: RTL

Timed producer for the DDS phase MAC input bus: it drives timestamp, time offset, frequency and phase words. Host commands arrive on a valid/ready stream and are buffered in a FIFO. Each command is applied on the exact cycle its apply_time equals the free-running timestamp. Sits between the RTIO/AXI command path and the phase MAC of each DAC channel.

---
 rtl/dds_sched_pkg.sv | 22 ++
 rtl/dds_param_scheduler_sync_fifo.sv | 57 +++++
 rtl/dds_param_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dds_sched_pkg.sv
// Shared types for the DDS parameter scheduler: command record, FSM states and
// default widths.
package dds_sched_pkg;

  localparam int DDS_TS_W = 48;
  localparam int DDS_PH_W = 14;

  // Field widths follow the package defaults; the scheduler casts its ports onto them.
  typedef struct packed {
    logic [DDS_TS_W-1:0] apply_time;
    logic [DDS_TS_W-1:0] freq;
    logic [DDS_PH_W-1:0] phase;
    logic                sync;
  } dds_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    APPLY = 2'd2
  } sched_state_t;

endpackage

// File: rtl/dds_param_scheduler_sync_fifo.sv
// Single-clock FIFO of an arbitrary packed type with occupancy count and
// full/empty flags; read data is the current head entry (show-ahead).
module sync_fifo #(
  parameter type T = logic [7:0],
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  T            wdata,
  input  logic        pop,
  output T            rdata,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  T            mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dds_param_scheduler.sv
// Timed producer for the DDS phase MAC: buffers host commands and applies each one
// on the cycle its apply_time equals the timestamp. Option: DDS_SCHED_LATE_DROP_EN.
module dds_param_scheduler
  import dds_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = DDS_TS_W,
  parameter int PH_W       = DDS_PH_W,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [TS_W-1:0] s_apply_time,
  input  logic [TS_W-1:0] s_freq,
  input  logic [PH_W-1:0] s_phase,
  input  logic            s_sync,
  input  logic            ts_clear,
  input  logic            err_clr,
  output logic [TS_W-1:0] timestamp,
  output logic [TS_W-1:0] time_offset,
  output logic [TS_W-1:0] freq,
  output logic [PH_W-1:0] phase,
  output logic            update,
  output logic            late_err,
  output logic [CW-1:0]   fifo_count
);

`ifdef DDS_SCHED_LATE_DROP_EN
  localparam bit LATE_DROP = 1'b1;
`else
  localparam bit LATE_DROP = 1'b0;
`endif

  dds_cmd_t     cmd_in;
  dds_cmd_t     fifo_rdata;
  dds_cmd_t     head;
  sched_state_t state;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_push;
  logic         fifo_pop;
  logic [TS_W-1:0] ts_next;
  logic [TS_W-1:0] head_time;
  logic         on_time;
  logic         late;
  logic         do_apply;

  assign s_ready   = resetn && !fifo_full;
  assign fifo_push = s_valid && s_ready;
  // Popping is allowed in the apply cycle too, giving a 2-cycle command spacing.
  assign fifo_pop  = (state != WAIT) && !fifo_empty;

  // Pack the incoming command onto the stored record.
  always_comb begin
    cmd_in            = '0;
    cmd_in.apply_time = DDS_TS_W'(s_apply_time);
    cmd_in.freq       = DDS_TS_W'(s_freq);
    cmd_in.phase      = DDS_PH_W'(s_phase);
    cmd_in.sync       = s_sync;
  end

  sync_fifo #(
    .T     (dds_cmd_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .wdata  (cmd_in),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Compare against the value the timestamp takes at the next edge so the
  // registered outputs line up with timestamp == apply_time.
  always_comb begin
    ts_next   = ts_clear ? '0 : timestamp + TS_W'(1);
    head_time = TS_W'(head.apply_time);
    on_time   = (head_time == ts_next);
    late      = (head_time < ts_next);
    do_apply  = (state == WAIT) && (on_time || (late && !LATE_DROP));
  end

  // Scheduler FSM with timestamp counter and registered MAC parameters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      head        <= '0;
      timestamp   <= '0;
      time_offset <= '0;
      freq        <= '0;
      phase       <= '0;
      update      <= 1'b0;
      late_err    <= 1'b0;
    end else begin
      timestamp <= ts_next;
      update    <= 1'b0;
      if (err_clr) begin
        late_err <= 1'b0;
      end
      if (do_apply) begin
        freq   <= TS_W'(head.freq);
        phase  <= PH_W'(head.phase);
        update <= 1'b1;
        if (head.sync) begin
          time_offset <= head_time;
        end
      end
      case (state)
        IDLE, APPLY: begin
          if (!fifo_empty) begin
            head  <= fifo_rdata;
            state <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          // Set of late_err is placed after the clear so it wins.
          if (late) begin
            late_err <= 1'b1;
          end
          if (do_apply) begin
            state <= APPLY;
          end else if (late) begin
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
